// File: rtl/vend_sequencer.sv
// -----------------------------------------------------------------------------
// vend_sequencer
// Sequencing controller for the vending-machine datapath. It synchronizes and
// edge-detects the coin inputs, accumulates credit in nickels, takes item
// selections and cancel from the keypad, checks credit against the external
// price ROM, and runs the vend, change-return and error phases.
//
// Ports:
//   CLK          system clock (1 kHz divided clock)
//   RESET        asynchronous, active-high reset
//   coin_in      raw coin levels {Nickel, Dime, Quarter, Dollar}, async to CLK
//   key          keypad code, valid while key_ready is high
//   key_ready    one-cycle strobe per keypress
//   price        price of item_sel in nickels from the price ROM (0 = invalid)
//   item_sel     latched item number (price ROM address)
//   credit       current credit in nickels
//   vend         dispense command
//   change_out   one-cycle pulse per nickel returned
//   err          insufficient credit / invalid item indication
//   coin_reject  one-cycle pulse when coins are refused
//   busy         high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module vend_sequencer #(
  parameter int CREDIT_W      = 6,
  parameter int MAX_CREDIT    = 60,
  parameter int VEND_CYCLES   = 1000,
  parameter int CHANGE_CYCLES = 200,
  parameter int ERR_CYCLES    = 500
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [3:0]          coin_in,
  input  logic [3:0]          key,
  input  logic                key_ready,
  input  logic [CREDIT_W-1:0] price,
  output logic [3:0]          item_sel,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                change_out,
  output logic                err,
  output logic                coin_reject,
  output logic                busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_VEND   = 3'd2;
  localparam logic [2:0] ST_CHANGE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  // One shared phase counter; it must reach the longest phase length minus one.
  localparam int CNT_MAX = (VEND_CYCLES > CHANGE_CYCLES) ?
                           ((VEND_CYCLES > ERR_CYCLES) ? VEND_CYCLES : ERR_CYCLES) :
                           ((CHANGE_CYCLES > ERR_CYCLES) ? CHANGE_CYCLES : ERR_CYCLES);
  localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  VEND_LAST = CNT_W'(VEND_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CHG_LAST  = CNT_W'(CHANGE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ERR_LAST  = CNT_W'(ERR_CYCLES - 1);
  localparam logic [CREDIT_W:0] MAX_W     = (CREDIT_W+1)'(MAX_CREDIT);

  // Sum of coin weights (nickels) for the coins whose rising edge was seen.
  function automatic logic [CREDIT_W:0] coin_value(input logic [3:0] rise);
    logic [CREDIT_W:0] v;
    v = {(CREDIT_W+1){1'b0}};
    if (rise[3]) v = v + (CREDIT_W+1)'(5'd1);
    if (rise[2]) v = v + (CREDIT_W+1)'(5'd2);
    if (rise[1]) v = v + (CREDIT_W+1)'(5'd5);
    if (rise[0]) v = v + (CREDIT_W+1)'(5'd20);
    return v;
  endfunction

  logic [3:0]          sync1_r, sync2_r, hist_r;
  logic [2:0]          state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [CREDIT_W-1:0] credit_r, credit_s;
  logic [3:0]          item_sel_r, item_sel_s;
  logic                vend_r, change_r, err_r, reject_r, busy_r, reject_s;
  logic [CREDIT_W:0]   coin_sum_s, credit_add_s;

  assign coin_sum_s   = coin_value(sync2_r & ~hist_r);
  assign credit_add_s = {1'b0, credit_r} + coin_sum_s;

  // Next-state, credit and counter logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    credit_s   = credit_r;
    item_sel_s = item_sel_r;
    // Coins outside IDLE are always refused; IDLE decides below.
    reject_s   = (coin_sum_s != {(CREDIT_W+1){1'b0}});
    case (state_r)
      ST_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        // Coin credit is applied first so a same-cycle cancel sees it.
        if (coin_sum_s == {(CREDIT_W+1){1'b0}}) begin
          reject_s = 1'b0;
        end else if (credit_add_s > MAX_W) begin
          reject_s = 1'b1;
        end else begin
          reject_s = 1'b0;
          credit_s = credit_add_s[CREDIT_W-1:0];
        end
        if (key_ready) begin
          if (key <= 4'd9) begin
            item_sel_s = key;
            state_s    = ST_CHECK;
          end else if (key == 4'hA) begin
            state_s = (credit_s != {CREDIT_W{1'b0}}) ? ST_CHANGE : ST_IDLE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        cnt_s = {CNT_W{1'b0}};
        if (price == {CREDIT_W{1'b0}}) begin
          state_s = ST_ERROR;
        end else if (credit_r >= price) begin
          credit_s = credit_r - price;
          state_s  = ST_VEND;
        end else begin
          state_s = ST_ERROR;
        end
      end
      ST_VEND: begin
        if (cnt_r == VEND_LAST) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = (credit_r != {CREDIT_W{1'b0}}) ? ST_CHANGE : ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_CHANGE: begin
        if (credit_r == {CREDIT_W{1'b0}}) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_IDLE;
        end else if (cnt_r == CHG_LAST) begin
          // Return one nickel; leave as soon as the last one goes out.
          cnt_s    = {CNT_W{1'b0}};
          credit_s = credit_r - CREDIT_W'(1'b1);
          state_s  = (credit_s == {CREDIT_W{1'b0}}) ? ST_IDLE : ST_CHANGE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_ERROR: begin
        if (cnt_r == ERR_LAST) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, synchronizer and registered outputs (decoded from next state).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_r    <= 4'd0;
      sync2_r    <= 4'd0;
      hist_r     <= 4'd0;
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      credit_r   <= {CREDIT_W{1'b0}};
      item_sel_r <= 4'd0;
      vend_r     <= 1'b0;
      change_r   <= 1'b0;
      err_r      <= 1'b0;
      reject_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      sync1_r    <= coin_in;
      sync2_r    <= sync1_r;
      hist_r     <= sync2_r;
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      credit_r   <= credit_s;
      item_sel_r <= item_sel_s;
      vend_r     <= (state_s == ST_VEND);
      change_r   <= (state_s == ST_CHANGE) && (cnt_s == CHG_LAST);
      err_r      <= (state_s == ST_ERROR);
      reject_r   <= reject_s;
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign item_sel    = item_sel_r;
  assign credit      = credit_r;
  assign vend        = vend_r;
  assign change_out  = change_r;
  assign err         = err_r;
  assign coin_reject = reject_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_vend_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vend_sequencer
// Directed self-checking bench for vend_sequencer with short phase lengths
// (VEND_CYCLES=4, CHANGE_CYCLES=2, ERR_CYCLES=3). Inputs are driven and
// outputs sampled on the falling clock edge. A small price table stands in
// for the price ROM, addressed by item_sel.
// -----------------------------------------------------------------------------
module tb_vend_sequencer;
  localparam int CW = 6;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [3:0]    coin_in;
  logic [3:0]    key;
  logic          key_ready;
  logic [CW-1:0] price;
  logic [3:0]    item_sel;
  logic [CW-1:0] credit;
  logic          vend, change_out, err, coin_reject, busy;

  logic [CW-1:0] price_tab [16];
  int vectors     = 0;
  int miscompares = 0;

  assign price = price_tab[item_sel];

  vend_sequencer #(
    .CREDIT_W(CW), .MAX_CREDIT(60), .VEND_CYCLES(4), .CHANGE_CYCLES(2), .ERR_CYCLES(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .coin_in(coin_in), .key(key), .key_ready(key_ready),
    .price(price), .item_sel(item_sel), .credit(credit), .vend(vend),
    .change_out(change_out), .err(err), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise coin bits, check the result three edges later, then release them.
  task automatic coin(input logic [3:0] c, input int exp_cr, input logic exp_rej, input string tag);
    coin_in = c;
    step(3);
    chk({tag, "_credit"}, 32'(credit), 32'(exp_cr));
    chk({tag, "_reject"}, 32'(coin_reject), 32'(exp_rej));
    coin_in = 4'd0;
    step(1);
    chk({tag, "_reject_end"}, 32'(coin_reject), 32'd0);
    step(2);
  endtask

  task automatic press(input logic [3:0] k);
    key       = k;
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
  endtask

  // Item with bad price or too little credit: 3 err cycles, credit kept.
  task automatic run_err(input logic [3:0] item, input int exp_cr, input string tag);
    press(item);
    chk({tag, "_check_busy"}, 32'({busy, err}), 32'd2);
    step(1);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_err_hi"}, 32'(err), 32'd1);
      chk({tag, "_err_credit"}, 32'(credit), 32'(exp_cr));
      step(1);
    end
    chk({tag, "_err_done"}, 32'({err, busy}), 32'd0);
    chk({tag, "_credit_kept"}, 32'(credit), 32'(exp_cr));
    chk({tag, "_item_kept"}, 32'(item_sel), 32'(item));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int cyc;
    int exp_cr [1:7];
    int exp_co [1:7];
    exp_cr = '{3, 3, 2, 2, 1, 1, 0};
    exp_co = '{0, 1, 0, 1, 0, 1, 0};

    for (int i = 0; i < 16; i++) price_tab[i] = 6'd10;
    price_tab[1] = 6'd4;
    price_tab[2] = 6'd6;
    price_tab[3] = 6'd6;
    price_tab[5] = 6'd0;
    price_tab[7] = 6'd4;

    RESET = 1'b1; coin_in = 4'd0; key = 4'd0; key_ready = 1'b0;
    step(2);
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_item", 32'(item_sel), 32'd0);
    chk("rst_outs", 32'({vend, change_out, err, coin_reject, busy}), 32'd0);
    RESET = 1'b0;
    step(1);

    // 1: quarter then dime
    coin_in = 4'b0010;
    step(2);
    chk("t1_latency", 32'(credit), 32'd0);
    step(1);
    chk("t1_quarter", 32'(credit), 32'd5);
    chk("t1_q_reject", 32'(coin_reject), 32'd0);
    coin_in = 4'd0;
    step(3);
    coin(4'b0100, 7, 1'b0, "t1_dime");

    // 2: buy item 3 (price 6) with credit 7
    press(4'd3);
    chk("t2_check", 32'({busy, vend}), 32'd2);
    chk("t2_item", 32'(item_sel), 32'd3);
    step(1);
    chk("t2_credit", 32'(credit), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("t2_vend_hi", 32'(vend), 32'd1);
      step(1);
    end
    chk("t2_vend_lo", 32'({vend, change_out, busy}), 32'd1);
    step(1);
    chk("t2_change", 32'({change_out, credit}), 32'({1'b1, 6'd1}));
    step(1);
    chk("t2_idle", 32'({change_out, busy, credit}), 32'd0);

    // 3: insufficient credit, then sold-out item
    coin(4'b0100, 2, 1'b0, "t3_dime1");
    coin(4'b0100, 4, 1'b0, "t3_dime2");
    run_err(4'd2, 4, "t3_short");
    run_err(4'd5, 4, "t3_soldout");

    // 4: ceiling handling
    coin(4'b0001, 24, 1'b0, "t4_d1");
    coin(4'b0001, 44, 1'b0, "t4_d2");
    coin(4'b0010, 49, 1'b0, "t4_q");
    coin(4'b1000, 50, 1'b0, "t4_n");
    coin(4'b0001, 50, 1'b1, "t4_dollar_over");
    coin(4'b0010, 55, 1'b0, "t4_q55");
    coin(4'b0010, 60, 1'b0, "t4_q60_at_max");
    coin(4'b1000, 60, 1'b1, "t4_n_over");
    press(4'hA);
    pulses = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 300) begin
      if (change_out === 1'b1) pulses++;
      step(1);
      cyc++;
    end
    chk("t4_cancel_done", 32'(cyc < 300), 32'd1);
    chk("t4_cancel_pulses", 32'(pulses), 32'd60);
    chk("t4_cancel_credit", 32'(credit), 32'd0);
    coin(4'b1100, 3, 1'b0, "t4_nickel_dime");

    // 5: cancel with 3 nickels; quarter during change is refused
    key = 4'hA; key_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk("t5_credit", 32'(credit), 32'(exp_cr[k]));
      chk("t5_change", 32'(change_out), 32'(exp_co[k]));
      chk("t5_reject", 32'(coin_reject), 32'(k == 4));
      chk("t5_busy", 32'(busy), 32'(k < 7));
      if (k == 1) begin
        key_ready = 1'b0;
        coin_in   = 4'b0010;
      end
      if (k == 5) coin_in = 4'd0;
    end
    step(3);
    chk("t5_credit_after", 32'(credit), 32'd0);

    // 6: async reset in 2nd vend cycle, then a key is accepted
    coin(4'b0001, 20, 1'b0, "t6_dollar");
    press(4'd7);
    step(1);
    chk("t6_vend1", 32'({vend, credit}), 32'({1'b1, 6'd16}));
    step(1);
    #2 RESET = 1'b1;
    #1 chk("t6_async_rst", 32'({vend, busy, credit}), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    step(1);
    press(4'd1);
    chk("t6_key_after_rst", 32'({busy, item_sel}), 32'({1'b1, 4'd1}));
    step(1);
    chk("t6_err_no_credit", 32'({err, credit}), 32'({1'b1, 6'd0}));
    step(3);
    chk("t6_idle", 32'({busy, err}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Sequencing controller for the vending-machine datapath. It edge-detects the four coin inputs and accumulates credit in nickel units. It accepts item selections and cancel from the keypad, checks credit against the price returned by an external price ROM, and sequences the vend, change-return and error phases. Its credit output feeds the existing coin-to-BCD conversion and multiplexed display; all logic runs on the 1 kHz system clock.

Parameters:
CREDIT_W, 6, credit/price width in nickels (63 max = $3.15)
MAX_CREDIT, 60, credit ceiling in nickels ($3.00)
VEND_CYCLES, 1000, cycles vend stays high (1 s at 1 kHz)
CHANGE_CYCLES, 200, cycles between change pulses
ERR_CYCLES, 500, cycles err stays high

Ports:
CLK  in  1  system clock (1 kHz divided clock)
RESET  in  1  asynchronous, active-high reset
coin_in  in  4  raw coin levels {Nickel, Dime, Quarter, Dollar}, asynchronous to CLK
key  in  4  keypad code, valid when key_ready is high
key_ready  in  1  one-cycle strobe per keypress
price  in  CREDIT_W  price of item_sel in nickels, combinational from price ROM; 0 = invalid/sold out
item_sel  out  4  latched item number
credit  out  CREDIT_W  current credit in nickels
vend  out  1  dispense command
change_out  out  1  one-cycle pulse per nickel returned
err  out  1  insufficient credit or invalid item indication
coin_reject  out  1  one-cycle pulse when coins are refused
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset clears all registers: state=IDLE; credit=0, item_sel=0, vend=0, change_out=0, err=0, coin_reject=0, busy=0. Synchronizer and edge-history flops also clear.
- Reset asserted mid-VEND or mid-CHANGE: vend and change_out drop immediately, credit is lost, no resume.
- Coins:
  - Each coin_in bit passes a 2-flop synchronizer, then a rising-edge detector.
  - Coin weights in nickels: Nickel=1, Dime=2, Quarter=5, Dollar=20.
  - Simultaneous edges in one cycle are summed.
  - Credit updates on the 3rd rising CLK edge after the input rises.
  - Coins are accepted only in IDLE.
  - If credit+sum > MAX_CREDIT, the whole cycle's sum is refused: credit unchanged, coin_reject pulses one cycle.
  - Edges arriving in any non-IDLE state are refused the same way, with coin_reject pulsing.
- Keys are honoured only in IDLE with key_ready=1; all other keys and states ignore the strobe.
  - key 0..9: item_sel<=key, go to CHECK.
  - key 0xA (cancel): if credit>0 go to CHANGE, else stay in IDLE.
  - 0xB..0xF: ignored.
  - A coin edge and a key strobe in the same IDLE cycle are both processed: credit adds first, state moves on the key.
- CHECK (exactly 1 cycle; price is sampled with item_sel already registered):
  - price==0 -> ERROR.
  - credit>=price -> credit<=credit-price, go to VEND.
  - otherwise -> ERROR, credit unchanged.
- VEND:
  - vend=1 from the first VEND cycle for exactly VEND_CYCLES cycles.
  - Then go to CHANGE if credit>0, else IDLE.
- CHANGE:
  - Cycle counter runs from 0.
  - When it reaches CHANGE_CYCLES-1: change_out=1 for that cycle, credit decrements by 1 at that edge, counter wraps to 0.
  - When credit reaches 0, go to IDLE on the next cycle. credit never underflows.
- ERROR: err=1 for ERR_CYCLES cycles, then IDLE; credit and item_sel are retained.
- busy = (state != IDLE).
- Width rules: all credit arithmetic uses CREDIT_W+1 bits internally; MAX_CREDIT must be < 2^CREDIT_W.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
Bench parameters: VEND_CYCLES=4, CHANGE_CYCLES=2, ERR_CYCLES=3.
1. Reset, then Quarter rise -> credit=5 three edges later; then Dime -> credit=7; coin_reject never pulses.
2. credit=7, key=3 with price=6 -> CHECK; credit=1, vend high 4 cycles; then one change_out pulse 2 cycles into CHANGE; credit=0; IDLE; busy low.
3. credit=4, key=2 with price=6 -> err high 3 cycles, credit stays 4, back to IDLE. Repeat with price=0 -> same err response.
4. credit=50, Dollar rise -> coin_reject one pulse, credit stays 50. Nickel and Dime rising in the same cycle from credit=0 -> credit=3.
5. credit=3, key=0xA -> change_out pulses every 2nd cycle, 3 pulses total, credit 3->2->1->0, then IDLE. A Quarter during CHANGE -> coin_reject, credit unaffected.
6. RESET asserted asynchronously in the 2nd vend cycle -> vend, credit and busy are 0 before the next CLK edge; a key strobe after release is accepted normally.
